// File: rtl/rx_link_reconfig_sequencer.sv
// RX link reconfiguration sequencer.
// Handles one GEN / lane-count change at a time. The sequence is:
// stall the datapath, drain in-flight lane data, flush the pipeline,
// then apply the new configuration. A rate change also waits for
// PhyStatus on every active lane before the datapath is released.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request; cfg is stable
// DRAIN    | hold asserted; wait for quiet active lanes or a timeout
// FLUSH    | hold + flush for FLUSH_CYCLES cycles
// APPLY    | load the pending cfg; branch on whether the rate changed
// WAIT_PHY | hold; collect sticky PhyStatus on the new active lanes
// DONE     | one-cycle done pulse with hold released
module rx_link_reconfig_sequencer #(
    parameter int LANES             = 16,
    parameter int DRAIN_IDLE_CYCLES = 4,
    parameter int FLUSH_CYCLES      = 3,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    input  logic [2:0]       req_gen_i,
    input  logic [4:0]       req_lanes_i,
    output logic             req_ready_o,
    input  logic [LANES-1:0] lane_valid_i,
    input  logic [LANES-1:0] phy_status_i,
    output logic [2:0]       cfg_gen_o,
    output logic [4:0]       cfg_lanes_o,
    output logic             dp_hold_o,
    output logic             dp_flush_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);

    localparam int QW = $clog2(DRAIN_IDLE_CYCLES + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_FLUSH, S_APPLY, S_WAIT_PHY, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cfg_gen_q, cfg_gen_d, pend_gen_q, pend_gen_d, prior_gen_q, prior_gen_d;
    logic [4:0]      cfg_lanes_q, cfg_lanes_d, pend_lanes_q, pend_lanes_d, prior_lanes_q, prior_lanes_d;
    logic [QW-1:0]   quiet_cnt_q, quiet_cnt_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [LANES-1:0] phy_mask_q, phy_mask_d;
    logic            done_pulse_q, done_pulse_d;
    logic            error_q, error_d;

    logic [LANES-1:0] active_mask;
    logic [LANES-1:0] phy_seen;
    logic             req_legal, req_same, lanes_quiet, phy_all, to_sat;

    // Active lanes follow cfg_lanes, so DRAIN sees the old width and WAIT_PHY the new one.
    always_comb begin
        active_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            active_mask[i] = (i < int'(cfg_lanes_q));
        end
        req_legal   = (req_gen_i >= 3'd1) && (req_gen_i <= 3'd5) &&
                      (req_lanes_i != 5'd0) && ((req_lanes_i & (req_lanes_i - 5'd1)) == 5'd0);
        req_same    = (req_gen_i == cfg_gen_q) && (req_lanes_i == cfg_lanes_q);
        lanes_quiet = ((lane_valid_i & active_mask) == '0);
        phy_seen    = phy_mask_q | phy_status_i;
        phy_all     = ((phy_seen & active_mask) == active_mask);
        to_sat      = (to_cnt_q == TW'(TIMEOUT_CYCLES));
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state plus the datapath registers that move with it.
    always_comb begin
        state_d       = state_q;
        cfg_gen_d     = cfg_gen_q;
        cfg_lanes_d   = cfg_lanes_q;
        pend_gen_d    = pend_gen_q;
        pend_lanes_d  = pend_lanes_q;
        prior_gen_d   = prior_gen_q;
        prior_lanes_d = prior_lanes_q;
        quiet_cnt_d   = quiet_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        to_cnt_d      = to_cnt_q;
        phy_mask_d    = phy_mask_q;
        done_pulse_d  = 1'b0;
        error_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (!req_legal) begin
                        error_d = 1'b1;
                    end else if (req_same) begin
                        done_pulse_d = 1'b1;
                    end else begin
                        pend_gen_d    = req_gen_i;
                        pend_lanes_d  = req_lanes_i;
                        prior_gen_d   = cfg_gen_q;
                        prior_lanes_d = cfg_lanes_q;
                        quiet_cnt_d   = '0;
                        to_cnt_d      = '0;
                        state_d       = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                to_cnt_d = to_sat ? to_cnt_q : to_cnt_q + TW'(1);
                if (!lanes_quiet) quiet_cnt_d = '0;
                else if (quiet_cnt_q != QW'(DRAIN_IDLE_CYCLES)) quiet_cnt_d = quiet_cnt_q + QW'(1);
                // A stuck lane must not wedge the link: on timeout, flush anyway.
                if ((lanes_quiet && quiet_cnt_q == QW'(DRAIN_IDLE_CYCLES - 1)) ||
                    to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    flush_cnt_d = '0;
                    state_d     = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q != FW'(FLUSH_CYCLES)) flush_cnt_d = flush_cnt_q + FW'(1);
                if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) state_d = S_APPLY;
            end
            S_APPLY: begin
                cfg_gen_d   = pend_gen_q;
                cfg_lanes_d = pend_lanes_q;
                if (pend_gen_q == cfg_gen_q) begin
                    state_d = S_DONE;
                end else begin
                    phy_mask_d = '0;
                    to_cnt_d   = '0;
                    state_d    = S_WAIT_PHY;
                end
            end
            S_WAIT_PHY: begin
                phy_mask_d = phy_seen;
                to_cnt_d   = to_sat ? to_cnt_q : to_cnt_q + TW'(1);
                if (phy_all) begin
                    state_d = S_DONE;
                end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    cfg_gen_d   = prior_gen_q;
                    cfg_lanes_d = prior_lanes_q;
                    error_d     = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Configuration, counters, masks and the registered pulses.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cfg_gen_q     <= 3'd1;
            cfg_lanes_q   <= 5'd1;
            pend_gen_q    <= '0;
            pend_lanes_q  <= '0;
            prior_gen_q   <= '0;
            prior_lanes_q <= '0;
            quiet_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            to_cnt_q      <= '0;
            phy_mask_q    <= '0;
            done_pulse_q  <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            cfg_gen_q     <= cfg_gen_d;
            cfg_lanes_q   <= cfg_lanes_d;
            pend_gen_q    <= pend_gen_d;
            pend_lanes_q  <= pend_lanes_d;
            prior_gen_q   <= prior_gen_d;
            prior_lanes_q <= prior_lanes_d;
            quiet_cnt_q   <= quiet_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            to_cnt_q      <= to_cnt_d;
            phy_mask_q    <= phy_mask_d;
            done_pulse_q  <= done_pulse_d;
            error_q       <= error_d;
        end
    end

    // Outputs decoded from state so hold/flush drop with reset immediately.
    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        busy_o      = (state_q != S_IDLE);
        dp_hold_o   = (state_q == S_DRAIN) || (state_q == S_FLUSH) ||
                      (state_q == S_APPLY) || (state_q == S_WAIT_PHY);
        dp_flush_o  = (state_q == S_FLUSH);
        done_o      = (state_q == S_DONE) || done_pulse_q;
        error_o     = error_q;
        cfg_gen_o   = cfg_gen_q;
        cfg_lanes_o = cfg_lanes_q;
    end

endmodule

// File: tb/tb_rx_link_reconfig_sequencer.sv
// Bench for rx_link_reconfig_sequencer: directed requests, a timeline
// model that derives every cycle's expected outputs from the stimulus,
// and literal spot checks on key cycles.
module tb_rx_link_reconfig_sequencer;

    localparam int MAXC    = 2400;
    localparam int TIMEOUT = 1024;

    typedef struct packed {
        logic       ready, hold, flush, busy, done, err;
        logic [2:0] gen;
        logic [4:0] lanes;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic [2:0]  req_gen_i = '0;
    logic [4:0]  req_lanes_i = '0;
    logic [15:0] lane_valid_i = '0;
    logic [15:0] phy_status_i = '0;
    logic        req_ready_o, dp_hold_o, dp_flush_o, busy_o, done_o, error_o;
    logic [2:0]  cfg_gen_o;
    logic [4:0]  cfg_lanes_o;

    rx_link_reconfig_sequencer dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_gen_i(req_gen_i), .req_lanes_i(req_lanes_i),
        .req_ready_o(req_ready_o),
        .lane_valid_i(lane_valid_i), .phy_status_i(phy_status_i),
        .cfg_gen_o(cfg_gen_o), .cfg_lanes_o(cfg_lanes_o),
        .dp_hold_o(dp_hold_o), .dp_flush_o(dp_flush_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        chk_on = 1'b0;
    int          cur_gen = 1;
    int          cur_lanes = 1;
    logic [15:0] lv [MAXC];
    logic [15:0] ps [MAXC];
    exp_t        ex [MAXC];

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            lane_valid_i = lv[cyc];
            phy_status_i = ps[cyc];
        end
    end

    function automatic exp_t mk(input logic r, h, f, b, d, e, input int g, input int l);
        exp_t x;
        x.ready = r; x.hold = h; x.flush = f; x.busy = b; x.done = d; x.err = e;
        x.gen = 3'(g); x.lanes = 5'(l);
        return x;
    endfunction

    function automatic logic [15:0] lmask(input int n);
        logic [15:0] m;
        for (int i = 0; i < 16; i++) m[i] = (i < n);
        return m;
    endfunction

    task automatic fill_idle(input int from, input int g, input int l);
        for (int c = from; c < MAXC; c++) ex[c] = mk(1, 0, 0, 0, 0, 0, g, l);
    endtask

    // Timeline model: from request cycle t, lay out drain / flush / apply / phy wait.
    task automatic plan(input int t, input int g, input int l);
        int run, de, w0, dn;
        logic [15:0] mo, mn, seen;
        logic legal;
        legal = (g >= 1) && (g <= 5) && (l == 1 || l == 2 || l == 4 || l == 8 || l == 16);
        if (!legal) begin
            fill_idle(t + 1, cur_gen, cur_lanes);
            ex[t + 1].err = 1'b1;
            return;
        end
        if (g == cur_gen && l == cur_lanes) begin
            fill_idle(t + 1, cur_gen, cur_lanes);
            ex[t + 1].done = 1'b1;
            return;
        end
        mo = lmask(cur_lanes);
        mn = lmask(l);
        run = 0;
        de = t + TIMEOUT;
        for (int c = t + 1; c <= t + TIMEOUT; c++) begin
            if ((lv[c] & mo) == 16'h0) run++; else run = 0;
            if (run == 4) begin de = c; break; end
        end
        for (int c = t + 1; c <= de; c++) ex[c] = mk(0, 1, 0, 1, 0, 0, cur_gen, cur_lanes);
        for (int c = de + 1; c <= de + 3; c++) ex[c] = mk(0, 1, 1, 1, 0, 0, cur_gen, cur_lanes);
        ex[de + 4] = mk(0, 1, 0, 1, 0, 0, cur_gen, cur_lanes);
        w0 = de + 5;
        if (g == cur_gen) begin
            ex[w0] = mk(0, 0, 0, 1, 1, 0, g, l);
            fill_idle(w0 + 1, g, l);
            cur_gen = g; cur_lanes = l;
            return;
        end
        seen = '0;
        dn = -1;
        for (int c = w0; c < w0 + TIMEOUT; c++) begin
            seen |= ps[c];
            ex[c] = mk(0, 1, 0, 1, 0, 0, g, l);
            if ((seen & mn) == mn) begin dn = c + 1; break; end
        end
        if (dn >= 0) begin
            ex[dn] = mk(0, 0, 0, 1, 1, 0, g, l);
            fill_idle(dn + 1, g, l);
            cur_gen = g; cur_lanes = l;
        end else begin
            fill_idle(w0 + TIMEOUT, cur_gen, cur_lanes);
            ex[w0 + TIMEOUT].err = 1'b1;
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc != n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic lit(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, want);
        end
    endtask

    task automatic do_req(input int t, input int g, input int l);
        wait_until(t);
        plan(t, g, l);
        req_valid_i = 1'b1;
        req_gen_i   = 3'(g);
        req_lanes_i = 5'(l);
        wait_until(t + 1);
        req_valid_i = 1'b0;
    endtask

    // Every-cycle comparison of all outputs against the model timeline.
    initial begin
        exp_t act;
        forever begin
            @(negedge clk_i);
            if (chk_on) begin
                act = mk(req_ready_o, dp_hold_o, dp_flush_o, busy_o, done_o, error_o,
                         int'(cfg_gen_o), int'(cfg_lanes_o));
                checks++;
                if (act !== ex[cyc]) begin
                    failures++;
                    $display("FAIL timeline cycle=%0d got rdy%b hold%b flush%b busy%b done%b err%b gen%0d lanes%0d want rdy%b hold%b flush%b busy%b done%b err%b gen%0d lanes%0d",
                             cyc, act.ready, act.hold, act.flush, act.busy, act.done, act.err, act.gen, act.lanes,
                             ex[cyc].ready, ex[cyc].hold, ex[cyc].flush, ex[cyc].busy, ex[cyc].done,
                             ex[cyc].err, ex[cyc].gen, ex[cyc].lanes);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int c = 0; c < MAXC; c++) begin lv[c] = '0; ps[c] = '0; end
        fill_idle(0, 1, 1);
        lv[61] = 16'h0200; lv[62] = 16'h0200; lv[63] = 16'h0200; lv[64] = 16'h0200;
        lv[83] = 16'h0001;
        ps[40] = 16'h0020; ps[42] = 16'h0001; ps[45] = 16'h0002;
        ps[1196] = 16'h0001;

        wait_until(3);
        reset_i = 1'b0;
        chk_on  = 1'b1;
        wait_until(4);
        lit("reset_gen", int'(cfg_gen_o), 1);
        lit("reset_lanes", int'(cfg_lanes_o), 1);
        lit("reset_ready", int'(req_ready_o), 1);

        // lane-only change on an idle datapath
        do_req(10, 1, 2);
        wait_until(14); lit("t1_flush_before", int'(dp_flush_o), 0); lit("t1_hold", int'(dp_hold_o), 1);
        wait_until(15); lit("t1_flush_start", int'(dp_flush_o), 1);
        wait_until(19); lit("t1_done", int'(done_o), 1); lit("t1_lanes", int'(cfg_lanes_o), 2);
        wait_until(20); lit("t1_ready", int'(req_ready_o), 1);

        // rate change, PhyStatus on different cycles, stray inactive lane first
        do_req(30, 3, 2);
        wait_until(41); lit("t2_lane5_ignored", int'(done_o), 0); lit("t2_hold", int'(dp_hold_o), 1);
        wait_until(45); lit("t2_not_yet", int'(done_o), 0);
        wait_until(46); lit("t2_done", int'(done_o), 1); lit("t2_gen", int'(cfg_gen_o), 3);

        // inactive lane valid ignored during drain
        do_req(60, 3, 4);
        wait_until(65); lit("t3b_flush", int'(dp_flush_o), 1);
        // active lane valid restarts the quiet count
        do_req(80, 3, 2);
        wait_until(87); lit("t3a_no_flush", int'(dp_flush_o), 0);
        wait_until(88); lit("t3a_flush", int'(dp_flush_o), 1);

        // illegal and identical requests
        do_req(100, 6, 2);
        lit("t5_err_gen6", int'(error_o), 1); lit("t5_nohold", int'(dp_hold_o), 0);
        do_req(103, 2, 3);
        lit("t5_err_lanes3", int'(error_o), 1);
        do_req(106, 3, 2);
        lit("t5_same_done", int'(done_o), 1); lit("t5_same_nohold", int'(dp_hold_o), 0);
        do_req(109, 0, 4);
        lit("t5_err_gen0", int'(error_o), 1);

        // PhyStatus never arrives -> timeout and revert
        do_req(120, 5, 16);
        wait_until(1152); lit("t4_hold_late", int'(dp_hold_o), 1); lit("t4_gen_new", int'(cfg_gen_o), 5);
        wait_until(1153);
        lit("t4_err", int'(error_o), 1); lit("t4_gen_back", int'(cfg_gen_o), 3);
        lit("t4_lanes_back", int'(cfg_lanes_o), 2); lit("t4_nohold", int'(dp_hold_o), 0);
        lit("t4_nodone", int'(done_o), 0);

        // reset during FLUSH, then a fresh sequence
        do_req(1170, 4, 8);
        wait_until(1175); lit("t6_in_flush", int'(dp_flush_o), 1);
        wait_until(1176);
        reset_i = 1'b1;
        #1;
        lit("t6_flush_drop", int'(dp_flush_o), 0); lit("t6_hold_drop", int'(dp_hold_o), 0);
        lit("t6_busy", int'(busy_o), 0); lit("t6_gen", int'(cfg_gen_o), 1);
        lit("t6_lanes", int'(cfg_lanes_o), 1);
        fill_idle(1176, 1, 1);
        cur_gen = 1; cur_lanes = 1;
        wait_until(1178);
        reset_i = 1'b0;
        do_req(1185, 2, 1);
        wait_until(1197); lit("t6_post_done", int'(done_o), 1); lit("t6_post_gen", int'(cfg_gen_o), 2);

        wait_until(1210);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_link_reconfig_sequencer.md
Name: rx_link_reconfig_sequencer

Overview:
Sequences every change of negotiated rate (GEN) and active lane count on the RX datapath (PIPE receive, descrambler, lane merge, ordered-set decoder, packet identifier). It accepts one reconfiguration request at a time and performs four steps: stall the datapath, drain in-flight lane data, flush the pipeline stages, then apply the new configuration. For a rate change it then waits for PhyStatus from every active lane before releasing the datapath. It sits between the LTSSM/rate-negotiation logic and the RX datapath, and drives the GEN and lane-count configuration those modules consume.

Parameters:
LANES, 16, number of physical lanes (the width of the per-lane vectors)
DRAIN_IDLE_CYCLES, 4, consecutive quiet cycles required to declare the datapath drained
FLUSH_CYCLES, 3, cycles dp_flush is held asserted
TIMEOUT_CYCLES, 1024, maximum cycles allowed in DRAIN and, separately, in WAIT_PHY

Ports:
clk  in  1  datapath clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  reconfiguration request valid
req_gen  in  3  requested rate, legal values 1..5
req_lanes  in  5  requested lane count, legal values {1,2,4,8,16}
req_ready  out  1  request can be accepted
lane_valid  in  LANES  per-lane valid from the lane-merge stage
phy_status  in  LANES  per-lane PhyStatus from the PHY
cfg_gen  out  3  active rate fed to the datapath
cfg_lanes  out  5  active lane count fed to the datapath
dp_hold  out  1  datapath stall (stops new data acceptance)
dp_flush  out  1  synchronous clear of the datapath pipeline registers
busy  out  1  a sequence is in progress
done  out  1  one-cycle pulse: configuration applied and datapath released
error  out  1  one-cycle pulse: request rejected or sequence aborted

Behaviour:
- Reset values: cfg_gen=1, cfg_lanes=1, all other outputs 0, state IDLE, all counters and masks 0. Reset is asynchronous and abandons any sequence in progress; dp_hold and dp_flush drop immediately.
- req_ready=1 only in IDLE. A request is accepted on a cycle with req_valid & req_ready.
- Illegal request (req_gen of 0, 6 or 7, or req_lanes not a power of two in 1..16): error pulses the next cycle, the state stays IDLE, cfg is unchanged.
- Request identical to the current cfg: done pulses the next cycle, the state stays IDLE, and there is no hold or flush.
- Otherwise, latch pending gen and lanes, save prior cfg, and enter DRAIN.
- Active-lane mask = low cfg_lanes bits (uses the current cfg in DRAIN, the new cfg in WAIT_PHY).
- DRAIN: dp_hold=1, busy=1.
  - The quiet counter increments each cycle that (lane_valid & mask)==0 and clears to 0 on any masked valid.
  - Counter reaching DRAIN_IDLE_CYCLES -> FLUSH.
  - The DRAIN timeout counter reaching TIMEOUT_CYCLES -> FLUSH anyway; data is discarded and no error is raised.
- FLUSH: dp_hold=1, dp_flush=1 for exactly FLUSH_CYCLES cycles, then APPLY.
- APPLY: one cycle with dp_hold=1. cfg_gen and cfg_lanes load the pending values and are visible the next cycle. If the gen is unchanged (lane-only change) -> DONE; else clear the phy mask and timeout counter and go to WAIT_PHY.
- WAIT_PHY: dp_hold=1.
  - phy_mask |= phy_status each cycle (sticky, so pulses on different cycles count).
  - When (phy_mask & new active mask) == new active mask -> DONE. phy_status on inactive lanes is ignored.
  - Timeout at TIMEOUT_CYCLES: cfg reverts to the saved prior values, error pulses, dp_hold drops, -> IDLE (no done).
- DONE: done=1 for one cycle, dp_hold=0, -> IDLE.
- busy=1 in every state except IDLE. req_valid in a non-IDLE state is ignored and must be held by the requester.
- Minimum latency (idle datapath, default parameters, acceptance at cycle T):
  - Lane-only change: DRAIN T+1..T+4, FLUSH T+5..T+7, APPLY T+8, DONE T+9, with new cfg visible at T+9.
  - Rate change: WAIT_PHY begins at T+9.
- Counters saturate and never wrap.

Test Plan:
1. After reset, check cfg_gen=1, cfg_lanes=1, req_ready=1. Request gen=1, lanes=2 with lane_valid=0 -> dp_hold high T+1..T+8, dp_flush high T+5..T+7, cfg_lanes=2 and done=1 at T+9, req_ready=1 at T+10.
2. Rate change to gen=3, lanes=2; phy_status lane0 pulse at T+12 and lane1 at T+15 -> done at T+16, cfg_gen=3; a lane5 phy_status pulse alone does not complete the sequence.
3. In DRAIN, drive lane_valid[0]=1 at T+3 -> quiet counter restarts and FLUSH starts at T+8. lane_valid[9]=1 with lanes=2 -> ignored, FLUSH still starts at T+5.
4. Rate change with phy_status never asserted -> error pulses when the WAIT_PHY counter reaches 1024, cfg returns to its prior values, dp_hold=0, done is never asserted.
5. Requests with req_gen=6 or req_lanes=3 -> error the next cycle, no dp_hold. A request equal to the current cfg -> done the next cycle, no dp_hold.
6. Assert reset during FLUSH -> dp_flush and dp_hold drop in the same cycle, cfg_gen=1 and cfg_lanes=1, busy=0; a new request after reset completes normally.
